regfile_scoreboard: RTL
=======================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 32: register count, a power of two and at least 2; AW = log2(NUM_REGS).
REQ-003 SHALL have parameter NUM_RD, default 2: number of independent read ports, 1 to 4.
REQ-004 SHALL have port Clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of Clk.
REQ-006 SHALL have port rd_addr, input, NUM_RD*AW bits: read addresses; port k occupies bits [k*AW +: AW].
REQ-007 SHALL have port rd_data, output, NUM_RD*DATA_W bits: read data; port k occupies bits [k*DATA_W +: DATA_W].
REQ-008 SHALL have port rd_busy, output, NUM_RD bits: bit k = 1 means port k's register has an outstanding producer.
REQ-009 SHALL have port wr_en, input, 1 bit: write-back strobe.
REQ-010 SHALL have port wr_addr, input, AW bits: write-back destination.
REQ-011 SHALL have port wr_data, input, DATA_W bits: write-back value.
REQ-012 SHALL have port issue_en, input, 1 bit: marks a destination as pending.
REQ-013 SHALL have port issue_addr, input, AW bits: destination being issued.
REQ-014 SHALL have port busy_count, output, AW+1 bits: number of registers currently pending.

Function
REQ-015 Register 0 SHALL read as zero and never be busy; writes and issues to address 0 SHALL be ignored.
REQ-016 Reads SHALL be combinational (zero latency).
REQ-017 Writes SHALL commit on the Clk edge where wr_en=1.
REQ-018 Write-through bypass: if wr_en=1, wr_addr!=0 and wr_addr equals a port's rd_addr, that port's rd_data SHALL equal wr_data in the same cycle.
REQ-019 A busy bit SHALL be set on the edge where issue_en=1 (issue_addr!=0).
REQ-020 A busy bit SHALL be cleared on the edge where wr_en=1 for that address.
REQ-021 If issue_en and wr_en target the same address on the same edge, issue SHALL win: busy stays 1 and the data is still written.
REQ-022 Issue to an already-busy address SHALL leave it busy; busy_count SHALL not change.
REQ-023 Write to a non-busy address SHALL commit data; busy SHALL stay 0.
REQ-024 rd_busy[k] SHALL equal busy[rd_addr_k] AND NOT (wr_en=1 with wr_addr=rd_addr_k), so the bypassed value reads as ready.
REQ-025 busy_count SHALL be registered and equal the population count of busy bits after each edge; its maximum is NUM_REGS-1.
REQ-026 All read ports SHALL be mutually independent; any ports may use the same address.

Reset
REQ-027 While reset=0 at an edge, all registers SHALL clear to 0, all busy bits to 0 and busy_count to 0; wr_en and issue_en SHALL be ignored on that edge.
REQ-028 Reset asserted mid-operation SHALL discard all pending state; the first edge after release SHALL behave as from power-up.
REQ-029 After reset, every rd_data SHALL be 0 and every rd_busy SHALL be 0.

Structure
REQ-030 A shared package SHALL hold the default DATA_W, NUM_REGS and NUM_RD values and the AW derivation function.
REQ-031 Read-port logic (mux, bypass, busy mask) SHALL be one sub-module, regfile_read_port, instantiated NUM_RD times.
REQ-032 Data storage and scoreboard SHALL live in the top module; there SHALL be no other sub-modules.

Verification
REQ-033 Reset then write r1=56: next cycle rd_addr0=1 gives rd_data0=56; a write to r1 with wr_en=0 leaves r1=56.
REQ-034 Write r0=0xFFFFFFFF, then issue r0: rd_data=0, rd_busy=0, busy_count=0.
REQ-035 Issue r5, then read r5: rd_busy=1 and busy_count=1. Next cycle write r5=20 with rd_addr=5: same cycle rd_data=20 and rd_busy=0; after the edge busy_count=0.
REQ-036 Issue r7 and write r7=9 on the same edge: r7 reads 9, rd_busy=1, busy_count=1.
REQ-037 Issue r1, r2, r3 over three cycles, then assert reset for one edge: busy_count=0 and all registers read 0.
REQ-038 NUM_RD=4 with all ports at address 3 while wr_en writes r3=0xA5: all four ports read 0xA5 with rd_busy=0.

Source files
------------

// File: rtl/regfile_scoreboard_pkg.sv
// Shared defaults and helpers for the register file with busy-bit scoreboard.
package regfile_scoreboard_pkg;

  localparam int DEFAULT_DATA_W   = 32;
  localparam int DEFAULT_NUM_REGS = 32;
  localparam int DEFAULT_NUM_RD   = 2;

  // Address width needed to index n registers (n is a power of two >= 2).
  function automatic int aw_of(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Bundle of the register-file access signals (read ports, write-back, issue,
// scoreboard status). The requester side is the master.
interface regfile_scoreboard_if
  import regfile_scoreboard_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int NUM_RD   = DEFAULT_NUM_RD
);
  localparam int AW = aw_of(NUM_REGS);

  logic [NUM_RD*AW-1:0]     rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [AW-1:0]            wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     issue_en;
  logic [AW-1:0]            issue_addr;
  logic [AW:0]              busy_count;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr,
    input  rd_data, rd_busy, busy_count
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr,
    output rd_data, rd_busy, busy_count
  );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port: register mux, write-through bypass and
// busy masking so a value being written back this cycle reads as ready.
module regfile_read_port
  import regfile_scoreboard_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  localparam int AW      = aw_of(NUM_REGS)
) (
  input  logic [AW-1:0]     rd_addr,
  input  logic [DATA_W-1:0] regs [NUM_REGS],
  input  logic [NUM_REGS-1:0] busy,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_busy
);

  logic rd_is_zero;
  logic wr_hit;

  // Register 0 is hardwired to zero, so it never bypasses and never reports busy.
  always_comb begin
    rd_is_zero = (rd_addr == '0);
    wr_hit     = wr_en && (wr_addr == rd_addr) && !rd_is_zero;
    rd_data    = '0;
    rd_busy    = 1'b0;
    if (wr_hit) begin
      rd_data = wr_data;
    end else if (!rd_is_zero) begin
      rd_data = regs[rd_addr];
    end
    if (!rd_is_zero) begin
      rd_busy = busy[rd_addr] && !wr_hit;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with a per-register busy scoreboard: issue marks a
// destination pending, write-back commits data and clears it. Issue wins
// over a same-edge write-back to the same register.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int NUM_RD   = DEFAULT_NUM_RD,
  localparam int AW      = aw_of(NUM_REGS)
) (
  input  logic                     Clk,
  input  logic                     reset,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     issue_en,
  input  logic [AW-1:0]            issue_addr,
  output logic [AW:0]              busy_count
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [AW:0]         busy_count_q;
  logic [AW:0]         busy_count_d;

  logic wr_ok;
  logic issue_ok;

  function automatic logic [AW:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      c = c + {{AW{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Next storage contents: write-back commits whether or not the register is busy.
  always_comb begin
    wr_ok    = wr_en && (wr_addr != '0);
    issue_ok = issue_en && (issue_addr != '0);
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_ok) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  // Next scoreboard: clear on write-back first, then set on issue so issue wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (issue_ok) begin
      busy_d[issue_addr] = 1'b1;
    end
    busy_count_d = popcount(busy_d);
  end

  // State update; reset discards all data and pending producers.
  always_ff @(posedge Clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign busy_count = busy_count_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_read_port #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS)
    ) u_rd (
      .rd_addr (rd_addr[k*AW +: AW]),
      .regs    (regs_q),
      .busy    (busy_q),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_data (rd_data[k*DATA_W +: DATA_W]),
      .rd_busy (rd_busy[k])
    );
  end

endmodule
